// File: rtl/ins_fetcher_if.sv
// Bundles the memory-controller and decoder signals of the instruction fetcher.
// The fetcher uses the master view; memory and decoder models use the slave view.
interface ins_fetcher_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        inst_input;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        is_stall;
    logic [31:0] next_PC;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;

    modport master (
        output mem_req, mem_addr, inst_input, inst, inst_addr,
        input  mem_ready, mem_data, is_stall, next_PC, rob_clear, rob_clear_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst_input, inst, inst_addr,
        output mem_ready, mem_data, is_stall, next_PC, rob_clear, rob_clear_pc
    );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetcher with a direct-mapped, one-word-per-line icache.
// Hits are presented to the decoder on the following edge. A miss issues a
// single memory read that is never withdrawn; a flush during an outstanding
// read parks in DROP until the word returns, so the line is still filled.
module ins_fetcher #(
    parameter int ICACHE_IDX_BIT = 4
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    ins_fetcher_if.master bus
);
    localparam int LINES = 1 << ICACHE_IDX_BIT;
    localparam int TAG_W = 32 - ICACHE_IDX_BIT - 2;

    typedef enum logic [1:0] {FETCH, WAIT_MEM, VALID, DROP} state_t;

    state_t                    r_state, w_stateNext;
    logic [31:0]               r_pc, w_pcNext;
    logic                      r_memReq, w_memReqNext;
    logic [31:0]               r_memAddr, w_memAddrNext;
    logic                      r_instValid, w_instValidNext;
    logic [31:0]               r_inst, w_instNext;
    logic [31:0]               r_instAddr, w_instAddrNext;
    logic [LINES-1:0]          r_lineValid;
    logic [TAG_W-1:0]          r_lineTag  [LINES];
    logic [31:0]               r_lineData [LINES];

    logic [ICACHE_IDX_BIT-1:0] w_lookupIdx;
    logic [TAG_W-1:0]          w_lookupTag;
    logic                      w_hit;
    logic                      w_memDone;
    logic                      w_fill;

    // Lookup address is next_PC while handing over to the next instruction, otherwise pc
    always_comb begin
        w_lookupIdx = r_pc[ICACHE_IDX_BIT+1:2];
        w_lookupTag = r_pc[31:ICACHE_IDX_BIT+2];
        if (r_state == VALID) begin
            w_lookupIdx = bus.next_PC[ICACHE_IDX_BIT+1:2];
            w_lookupTag = bus.next_PC[31:ICACHE_IDX_BIT+2];
        end
        w_hit = r_lineValid[w_lookupIdx] && (r_lineTag[w_lookupIdx] == w_lookupTag);
    end

    assign w_memDone = bus.mem_ready && r_memReq;

    // Next-state and next-output decisions; a flush always wins over other events
    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_memReqNext    = r_memReq;
        w_memAddrNext   = r_memAddr;
        w_instValidNext = r_instValid;
        w_instNext      = r_inst;
        w_instAddrNext  = r_instAddr;
        w_fill          = 1'b0;
        case (r_state)
            FETCH: begin
                if (bus.rob_clear) begin
                    w_pcNext = bus.rob_clear_pc;
                end else if (w_hit) begin
                    w_instNext      = r_lineData[w_lookupIdx];
                    w_instAddrNext  = r_pc;
                    w_instValidNext = 1'b1;
                    w_stateNext     = VALID;
                end else begin
                    w_memReqNext  = 1'b1;
                    w_memAddrNext = r_pc;
                    w_stateNext   = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (w_memDone) begin
                    w_fill       = 1'b1;
                    w_memReqNext = 1'b0;
                    if (bus.rob_clear) begin
                        w_pcNext    = bus.rob_clear_pc;
                        w_stateNext = FETCH;
                    end else begin
                        w_instNext      = bus.mem_data;
                        w_instAddrNext  = r_memAddr;
                        w_instValidNext = 1'b1;
                        w_stateNext     = VALID;
                    end
                end else if (bus.rob_clear) begin
                    w_pcNext    = bus.rob_clear_pc;
                    w_stateNext = DROP;
                end
            end
            VALID: begin
                if (bus.rob_clear) begin
                    w_pcNext        = bus.rob_clear_pc;
                    w_instValidNext = 1'b0;
                    w_stateNext     = FETCH;
                end else if (!bus.is_stall) begin
                    w_pcNext = bus.next_PC;
                    if (w_hit) begin
                        w_instNext     = r_lineData[w_lookupIdx];
                        w_instAddrNext = bus.next_PC;
                    end else begin
                        w_instValidNext = 1'b0;
                        w_memReqNext    = 1'b1;
                        w_memAddrNext   = bus.next_PC;
                        w_stateNext     = WAIT_MEM;
                    end
                end
            end
            DROP: begin
                if (bus.rob_clear) begin
                    w_pcNext = bus.rob_clear_pc;
                end
                if (w_memDone) begin
                    w_fill       = 1'b1;
                    w_memReqNext = 1'b0;
                    w_stateNext  = FETCH;
                end
            end
            default: begin
                w_stateNext = FETCH;
            end
        endcase
    end

    // Control and output registers; rdy_in low freezes everything except reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= FETCH;
            r_pc        <= '0;
            r_memReq    <= 1'b0;
            r_memAddr   <= '0;
            r_instValid <= 1'b0;
            r_inst      <= '0;
            r_instAddr  <= '0;
            r_lineValid <= '0;
        end else if (rdy_in) begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_memReq    <= w_memReqNext;
            r_memAddr   <= w_memAddrNext;
            r_instValid <= w_instValidNext;
            r_inst      <= w_instNext;
            r_instAddr  <= w_instAddrNext;
            if (w_fill) begin
                r_lineValid[r_memAddr[ICACHE_IDX_BIT+1:2]] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && w_fill) begin
            r_lineTag[r_memAddr[ICACHE_IDX_BIT+1:2]]  <= r_memAddr[31:ICACHE_IDX_BIT+2];
            r_lineData[r_memAddr[ICACHE_IDX_BIT+1:2]] <= bus.mem_data;
        end
    end

    assign bus.mem_req    = r_memReq;
    assign bus.mem_addr   = r_memAddr;
    assign bus.inst_input = r_instValid;
    assign bus.inst       = r_inst;
    assign bus.inst_addr  = r_instAddr;
endmodule

// File: tb/tb_ins_fetcher.sv
// Self-checking bench for ins_fetcher: directed scenarios followed by a random
// instruction walk, checked against an address-level model of cache residency.
module tb_ins_fetcher;
    logic clk = 1'b0;
    logic rstN;
    logic rdy;

    ins_fetcher_if bus ();

    ins_fetcher #(.ICACHE_IDX_BIT(4)) dut (
        .clk_in (clk),
        .rst_in (rstN),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] resAddr  [16];
    logic        resValid [16];

    // Memory image: every word address returns a fixed scramble; address 0 holds 0x13
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    function automatic int lineOf(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic logic isResident(input logic [31:0] a);
        return resValid[lineOf(a)] && ((resAddr[lineOf(a)] >> 2) == (a >> 2));
    endfunction

    function automatic logic [31:0] pickAddr();
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'($urandom_range(0, 3));
        lo = 32'($urandom_range(0, 15));
        return (hi << 12) | (lo << 2);
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 16; i++) begin
            resValid[i] = 1'b0;
            resAddr[i]  = '0;
        end
    endtask

    task automatic markResident(input logic [31:0] a);
        resValid[lineOf(a)] = 1'b1;
        resAddr[lineOf(a)]  = a;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic [31:0] nextPc);
        bus.is_stall = stall;
        bus.next_PC  = nextPc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that decides how address a is obtained
    task automatic expectDelivery(input logic [31:0] a, input int lat);
        if (isResident(a)) begin
            checkOutput("hitValid", 32'(bus.inst_input), 32'd1);
            checkOutput("hitAddr", bus.inst_addr, a);
            checkOutput("hitInst", bus.inst, memWord(a));
            checkOutput("hitNoReq", 32'(bus.mem_req), 32'd0);
        end else begin
            checkOutput("missReq", 32'(bus.mem_req), 32'd1);
            checkOutput("missAddr", bus.mem_addr, a);
            checkOutput("missNoInst", 32'(bus.inst_input), 32'd0);
            for (int k = 1; k < lat; k++) begin
                tick();
                checkOutput("waitReq", 32'(bus.mem_req), 32'd1);
                checkOutput("waitAddr", bus.mem_addr, a);
            end
            bus.mem_ready = 1'b1;
            bus.mem_data  = memWord(a);
            tick();
            bus.mem_ready = 1'b0;
            bus.mem_data  = $urandom;
            checkOutput("fillValid", 32'(bus.inst_input), 32'd1);
            checkOutput("fillAddr", bus.inst_addr, a);
            checkOutput("fillInst", bus.inst, memWord(a));
            checkOutput("fillReqDrop", 32'(bus.mem_req), 32'd0);
            markResident(a);
        end
    endtask

    task automatic consume(input logic [31:0] a, input int lat);
        applyStimulus(1'b0, a);
        tick();
        expectDelivery(a, lat);
    endtask

    task automatic flushTo(input logic [31:0] a, input int lat);
        bus.rob_clear    = 1'b1;
        bus.rob_clear_pc = a;
        tick();
        bus.rob_clear = 1'b0;
        checkOutput("flushNoInst", 32'(bus.inst_input), 32'd0);
        checkOutput("flushNoReq", 32'(bus.mem_req), 32'd0);
        tick();
        expectDelivery(a, lat);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstReq", 32'(bus.mem_req), 32'd0);
        checkOutput("rstMemAddr", bus.mem_addr, 32'd0);
        checkOutput("rstValid", 32'(bus.inst_input), 32'd0);
        checkOutput("rstInst", bus.inst, 32'd0);
        checkOutput("rstInstAddr", bus.inst_addr, 32'd0);
    endtask

    // Directed scenarios, then a random walk, then a mid-request reset
    initial begin
        logic [31:0] cur;
        logic [31:0] nxt;
        rstN = 1'b0;
        rdy  = 1'b1;
        bus.mem_ready    = 1'b0;
        bus.mem_data     = '0;
        bus.rob_clear    = 1'b0;
        bus.rob_clear_pc = '0;
        applyStimulus(1'b1, 32'd0);
        clearModel();
        tick();
        tick();
        checkResetOutputs();

        // Cold start: first request right after release, word 0x13 after three cycles
        rstN = 1'b1;
        tick();
        expectDelivery(32'h0, 3);

        // Preload 0x4..0xC, then replay 0x0..0xC as a bubble-free hit stream
        consume(32'h4, 1);
        consume(32'h8, 2);
        consume(32'hC, 1);
        flushTo(32'h0, 1);
        consume(32'h4, 1);
        consume(32'h8, 1);
        consume(32'hC, 1);

        // Stall hold at 0x8 for four cycles, consumed on the fifth edge
        flushTo(32'h8, 1);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 32'hC);
            tick();
            checkOutput("stallValid", 32'(bus.inst_input), 32'd1);
            checkOutput("stallAddr", bus.inst_addr, 32'h8);
            checkOutput("stallInst", bus.inst, memWord(32'h8));
        end
        consume(32'hC, 1);

        // Flush while the 0x40 miss is outstanding: word is dropped, then 0x100 fetched
        applyStimulus(1'b0, 32'h40);
        tick();
        checkOutput("dropMissReq", 32'(bus.mem_req), 32'd1);
        checkOutput("dropMissAddr", bus.mem_addr, 32'h40);
        applyStimulus(1'b1, 32'h0);
        tick();
        bus.rob_clear    = 1'b1;
        bus.rob_clear_pc = 32'h100;
        tick();
        bus.rob_clear = 1'b0;
        checkOutput("dropNoInst", 32'(bus.inst_input), 32'd0);
        checkOutput("dropReqHeld", 32'(bus.mem_req), 32'd1);
        checkOutput("dropAddrHeld", bus.mem_addr, 32'h40);
        tick();
        checkOutput("dropReqHeld2", 32'(bus.mem_req), 32'd1);
        checkOutput("dropAddrHeld2", bus.mem_addr, 32'h40);
        bus.mem_ready = 1'b1;
        bus.mem_data  = memWord(32'h40);
        tick();
        bus.mem_ready = 1'b0;
        checkOutput("dropNeverShown", 32'(bus.inst_input), 32'd0);
        checkOutput("dropReqDone", 32'(bus.mem_req), 32'd0);
        markResident(32'h40);
        tick();
        expectDelivery(32'h100, 2);

        // Flush coinciding with mem_ready: 0x40 word dropped, cached 0x4 follows
        applyStimulus(1'b0, 32'h40);
        tick();
        checkOutput("coinReq", 32'(bus.mem_req), 32'd1);
        checkOutput("coinAddr", bus.mem_addr, 32'h40);
        bus.rob_clear    = 1'b1;
        bus.rob_clear_pc = 32'h4;
        bus.mem_ready    = 1'b1;
        bus.mem_data     = memWord(32'h40);
        tick();
        bus.rob_clear = 1'b0;
        bus.mem_ready = 1'b0;
        checkOutput("coinNoInst", 32'(bus.inst_input), 32'd0);
        checkOutput("coinReqDone", 32'(bus.mem_req), 32'd0);
        markResident(32'h40);
        tick();
        expectDelivery(32'h4, 1);

        // Aliasing on line 0: 0x0 and 0x40 evict each other
        consume(32'h0, 2);
        consume(32'h40, 1);
        consume(32'h0, 1);

        // rdy_in low freezes a presented instruction and an outstanding request
        applyStimulus(1'b0, 32'h4);
        rdy = 1'b0;
        tick();
        tick();
        checkOutput("frzValid", 32'(bus.inst_input), 32'd1);
        checkOutput("frzAddr", bus.inst_addr, 32'h0);
        rdy = 1'b1;
        tick();
        expectDelivery(32'h4, 1);
        applyStimulus(1'b0, 32'h44);
        tick();
        rdy = 1'b0;
        tick();
        tick();
        rdy = 1'b1;
        expectDelivery(32'h44, 1);

        // Random walk over four tags x sixteen lines with stalls and flushes
        cur = 32'h44;
        for (int n = 0; n < 150; n++) begin
            int stalls;
            stalls = $urandom_range(0, 2);
            for (int s = 0; s < stalls; s++) begin
                applyStimulus(1'b1, $urandom);
                tick();
                checkOutput("rndStallAddr", bus.inst_addr, cur);
                checkOutput("rndStallInst", bus.inst, memWord(cur));
            end
            if ($urandom_range(0, 7) == 0) begin
                nxt = pickAddr();
                flushTo(nxt, $urandom_range(1, 4));
            end else begin
                nxt = ($urandom_range(0, 1) == 0) ? ((cur + 32'd4) & 32'h303C) : pickAddr();
                consume(nxt, $urandom_range(1, 4));
            end
            cur = nxt;
        end

        // Reset while a miss is outstanding and rdy_in is low clears the cache too
        applyStimulus(1'b0, 32'h7F00);
        tick();
        checkOutput("preRstReq", 32'(bus.mem_req), 32'd1);
        rstN = 1'b0;
        rdy  = 1'b0;
        tick();
        checkResetOutputs();
        clearModel();
        rstN = 1'b1;
        rdy  = 1'b1;
        applyStimulus(1'b1, 32'h0);
        tick();
        expectDelivery(32'h0, 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
